// File: rtl/uart_rx.sv
// UART 8-N-1 receiver: 2-FF synchronized rx, mid-bit sampling, start-glitch and stop-bit checks.
// Latency: 2 + N/2 + 9N clk from rx falling edge to done/frame_err (+-1 for edge phase).
// No backpressure: done/frame_err are one-cycle strobes; dout holds until the next good frame.
module uart_rx #(
    parameter int NUM_CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       done,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(NUM_CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(NUM_CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(NUM_CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   clk_cnt, clk_cnt_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shreg, shreg_nxt;
    logic [7:0]      dout_nxt;
    logic            done_nxt, frame_err_nxt;
    logic            rx_meta, rx_s;

    // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            dout      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            clk_cnt   <= clk_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shreg     <= shreg_nxt;
            dout      <= dout_nxt;
            done      <= done_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clk_cnt_nxt   = clk_cnt;
        bit_idx_nxt   = bit_idx;
        shreg_nxt     = shreg;
        dout_nxt      = dout;
        done_nxt      = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                clk_cnt_nxt = '0;
                if (!rx_s) state_nxt = START;
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = DATA;
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt = '0;
                    shreg_nxt   = {rx_s, shreg[7:1]};
                    if (bit_idx == 3'd7) state_nxt = STOP;
                    else                 bit_idx_nxt = bit_idx + 3'd1;
                end else begin
                    clk_cnt_nxt = clk_cnt + CW'(1);
                end
            end
            STOP: begin
                // Leaving at mid-stop gives half a bit of slack to catch a back-to-back start edge.
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = IDLE;
                    if (rx_s) begin
                        dout_nxt = shreg;
                        done_nxt = 1'b1;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at N=16 (directed cases) and N=4 / N=17 (parameter sweep).
module tb_uart_rx;

    typedef struct {
        int         dut;
        logic       is_err;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [2:0] rx_v;
    logic [7:0] dout_a [3];
    logic [2:0] done_v;
    logic [2:0] ferr_v;
    logic [2:0] busy_v;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    ev_t        q[$];
    logic [7:0] exp_dout [3];

    uart_rx #(.NUM_CLKS_PER_BIT(16)) u_n16 (
        .clk(clk), .rstn(rstn), .rx(rx_v[0]), .dout(dout_a[0]),
        .done(done_v[0]), .frame_err(ferr_v[0]), .busy(busy_v[0]));
    uart_rx #(.NUM_CLKS_PER_BIT(4)) u_n4 (
        .clk(clk), .rstn(rstn), .rx(rx_v[1]), .dout(dout_a[1]),
        .done(done_v[1]), .frame_err(ferr_v[1]), .busy(busy_v[1]));
    uart_rx #(.NUM_CLKS_PER_BIT(17)) u_n17 (
        .clk(clk), .rstn(rstn), .rx(rx_v[2]), .dout(dout_a[2]),
        .done(done_v[2]), .frame_err(ferr_v[2]), .busy(busy_v[2]));

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nclk(input int d);
        case (d)
            0:       return 16;
            1:       return 4;
            default: return 17;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected pulse time uses the nominal 2 + N/2 + 9N latency; the monitor allows +-1.
    task automatic send(input int d, input logic [7:0] b, input logic stop_bit);
        ev_t e;
        int  n;
        n = nclk(d);
        if (stop_bit) exp_dout[d] = b;
        e.dut    = d;
        e.is_err = !stop_bit;
        e.data   = exp_dout[d];
        e.cyc    = cyc + 2 + n / 2 + 9 * n;
        q.push_back(e);
        rx_v[d] = 1'b0;
        wait_cyc(n);
        for (int i = 0; i < 8; i++) begin
            rx_v[d] = b[i];
            wait_cyc(n);
        end
        rx_v[d] = stop_bit;
        wait_cyc(n);
        rx_v[d] = 1'b1;
    endtask

    task automatic drain(input int bound);
        for (int k = 0; k < bound; k++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_timeout_pending", 32'(q.size()), 32'd0);
        wait_cyc(2);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rstn) begin
            for (int i = 0; i < 3; i++) begin
                if (done_v[i] || ferr_v[i]) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_pulse dut%0d: done=%0b frame_err=%0b, required no pulse (cycle %0d)",
                                 i, done_v[i], ferr_v[i], cyc);
                    end else begin
                        e = q.pop_front();
                        chk("pulse_dut", 32'(i), 32'(e.dut));
                        chk("frame_err", 32'(ferr_v[i]), 32'(e.is_err));
                        chk("done", 32'(done_v[i]), 32'(!e.is_err));
                        chk("dout", 32'(dout_a[i]), 32'(e.data));
                        chk("busy_at_pulse", 32'(busy_v[i]), 32'd0);
                        n_cmp++;
                        if (cyc < e.cyc - 1 || cyc > e.cyc + 1) begin
                            n_err++;
                            $display("FAIL pulse_time dut%0d: got cycle %0d, required %0d +-1", i, cyc, e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", q.size());
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        rx_v = 3'b111;
        for (int i = 0; i < 3; i++) exp_dout[i] = 8'h00;
        wait_cyc(3);
        for (int i = 0; i < 3; i++) begin
            chk("rst_dout", 32'(dout_a[i]), 32'h00);
            chk("rst_done", 32'(done_v[i]), 32'd0);
            chk("rst_frame_err", 32'(ferr_v[i]), 32'd0);
            chk("rst_busy", 32'(busy_v[i]), 32'd0);
        end
        rstn = 1'b1;
        wait_cyc(5);

        send(0, 8'hA5, 1'b1);
        drain(400);

        // Stop bit low: frame_err only, dout keeps 0xA5.
        send(0, 8'h5A, 1'b0);
        drain(400);
        wait_cyc(40);
        chk("busy_after_ferr", 32'(busy_v[0]), 32'd0);

        // Back-to-back: no idle between first stop bit and second start bit.
        send(0, 8'h3C, 1'b1);
        send(0, 8'hC3, 1'b1);
        drain(400);

        // Reset during data bit 4 of 0xFF.
        rx_v[0] = 1'b0;
        wait_cyc(16);
        rx_v[0] = 1'b1;
        wait_cyc(4 * 16 + 8);
        chk("busy_mid_frame", 32'(busy_v[0]), 32'd1);
        #5;
        rstn = 1'b0;
        #1;
        chk("async_rst_dout", 32'(dout_a[0]), 32'h00);
        chk("async_rst_done", 32'(done_v[0]), 32'd0);
        chk("async_rst_frame_err", 32'(ferr_v[0]), 32'd0);
        chk("async_rst_busy", 32'(busy_v[0]), 32'd0);
        for (int i = 0; i < 3; i++) exp_dout[i] = 8'h00;
        wait_cyc(3);
        rstn = 1'b1;
        wait_cyc(5);
        send(0, 8'h81, 1'b1);
        drain(400);

        // Start glitch: 4 cycles low, then high.
        rx_v[0] = 1'b0;
        wait_cyc(4);
        rx_v[0] = 1'b1;
        wait_cyc(1);
        chk("glitch_busy_high", 32'(busy_v[0]), 32'd1);
        wait_cyc(16 / 2 + 2);
        chk("glitch_busy_low", 32'(busy_v[0]), 32'd0);
        wait_cyc(20);
        send(0, 8'h00, 1'b1);
        drain(400);

        // Parameter sweep at N=4 and N=17.
        for (int d = 1; d < 3; d++) begin
            send(d, 8'hFF, 1'b1);
            drain(400);
            send(d, 8'h01, 1'b1);
            drain(400);
        end

        wait_cyc(50);
        chk("final_pending", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
